coin_change_dispenser: RTL and testbench

Transmitter side of the vending coin interface. It takes a change amount, counted in nickels, and emits one-cycle nickel/dime pulses toward the coin hopper. It uses the same single-cycle pulse convention that the vending FSM consumes on its coin inputs. It sits beside the vending FSM, is driven by the pricing/credit logic, and falls back to nickels when the dime hopper is empty.

---
 rtl/coin_change_dispenser_pkg.sv | 7 +
 rtl/coin_change_dispenser_if.sv | 22 ++
 rtl/coin_change_dispenser_gap_timer.sv | 19 +
 rtl/coin_change_dispenser.sv | 83 ++++++++
 tb/tb_coin_change_dispenser.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/coin_change_dispenser_pkg.sv
// vend_pkg: shared coin and dispenser-state types plus coin values in nickel units
package vend_pkg;
  typedef enum logic {NICKEL, DIME} coin_t;
  typedef enum logic [1:0] {IDLE, COIN, GAP, DONE} dispense_state_t;
  localparam int NICKEL_VAL = 1;
  localparam int DIME_VAL = 2;
endpackage

// File: rtl/coin_change_dispenser_if.sv
// coin_change_dispenser_if: change request, hopper status and coin pulse signals
interface coin_change_dispenser_if #(parameter int AMOUNT_W = 4);
  logic req_valid;
  logic [AMOUNT_W-1:0] req_amount;
  logic req_ready;
  logic dime_empty;
  logic nickel_empty;
  logic nickel;
  logic dime;
  logic busy;
  logic done;
  logic error;
  logic [AMOUNT_W-1:0] shortfall;
  modport master (
    output req_valid, req_amount, dime_empty, nickel_empty,
    input req_ready, nickel, dime, busy, done, error, shortfall
  );
  modport slave (
    input req_valid, req_amount, dime_empty, nickel_empty,
    output req_ready, nickel, dime, busy, done, error, shortfall
  );
endinterface

// File: rtl/coin_change_dispenser_gap_timer.sv
// dispense_gap_timer: loadable down-counter flagging the last cycle of an inter-coin gap
module dispense_gap_timer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);
  localparam logic [3:0] LOAD_VAL = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  logic [3:0] cnt_q, cnt_d;
  // reload on gap entry, otherwise count down and park at zero
  always_comb cnt_d = load_i ? LOAD_VAL : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign expire_o = (cnt_q == 4'd0);
endmodule

// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: pays a nickel-denominated change amount as spaced nickel/dime pulses
module coin_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMOUNT_W   = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  coin_change_dispenser_if.slave bus
);
  dispense_state_t state_q, state_d;
  coin_t sel_q, sel_d;
  logic [AMOUNT_W-1:0] rem_q, rem_d, short_q, short_d, rem_src;
  logic err_q, err_d, use_dime, use_nickel, decide, expire, gap_load;
  dispense_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(gap_load),
    .expire_o(expire)
  );
  // coin choice: prefer a dime, fall back to a nickel, never underflow
  always_comb begin
    rem_src = (state_q == IDLE) ? bus.req_amount : rem_q;
    use_dime = rem_src >= AMOUNT_W'(DIME_VAL) && !bus.dime_empty;
    use_nickel = !use_dime && rem_src >= AMOUNT_W'(NICKEL_VAL) && !bus.nickel_empty;
  end
  // state register with remaining amount and held completion status
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= NICKEL;
      rem_q <= '0;
      err_q <= 1'b0;
      short_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rem_q <= rem_d;
      err_q <= err_d;
      short_q <= short_d;
    end
  // next state: decisions happen at acceptance, at gap expiry, or right after a coin when there is no gap
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rem_d = rem_q;
    err_d = err_q;
    short_d = short_q;
    decide = 1'b0;
    unique case (state_q)
      IDLE: decide = bus.req_valid;
      COIN:
        if (rem_q == '0) state_d = DONE;
        else if (GAP_CYCLES == 0) decide = 1'b1;
        else state_d = GAP;
      GAP: decide = expire;
      DONE: state_d = IDLE;
    endcase
    if (state_q == IDLE && bus.req_valid) begin
      err_d = 1'b0;
      short_d = '0;
    end
    if (decide) begin
      state_d = (use_dime || use_nickel) ? COIN : DONE;
      sel_d = use_dime ? DIME : NICKEL;
      rem_d = rem_src - (use_dime ? AMOUNT_W'(DIME_VAL) : use_nickel ? AMOUNT_W'(NICKEL_VAL) : AMOUNT_W'(0));
      err_d = !(use_dime || use_nickel) && rem_src != '0;
      short_d = (use_dime || use_nickel) ? '0 : rem_src;
    end
    gap_load = (state_q == COIN) && (state_d == GAP);
  end
  // outputs decoded purely from registered state
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy = (state_q != IDLE);
    bus.nickel = (state_q == COIN) && (sel_q == NICKEL);
    bus.dime = (state_q == COIN) && (sel_q == DIME);
    bus.done = (state_q == DONE);
    bus.error = err_q;
    bus.shortfall = short_q;
  end
endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb_coin_change_dispenser: randomized and directed checks against a coin-timeline reference model
module tb_coin_change_dispenser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit de[64];
  bit ne[64];
  int exp_coin[64];
  int exp_done;
  bit exp_err;
  int exp_sf;
  coin_change_dispenser_if #(.AMOUNT_W(4)) b0 ();
  coin_change_dispenser_if #(.AMOUNT_W(4)) b1 ();
  coin_change_dispenser #(.AMOUNT_W(4), .GAP_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  coin_change_dispenser #(.AMOUNT_W(4), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;

  // Reference: decision at cycle d uses the hopper flags of cycle d, the coin appears at d+1,
  // the next decision comes gap cycles after the coin; done follows the last coin or a failed decision.
  task automatic model(input int amt, input int gap);
    int rem, d;
    rem = amt;
    d = 0;
    foreach (exp_coin[i]) exp_coin[i] = 0;
    exp_err = 0;
    exp_sf = 0;
    if (rem == 0) exp_done = 1;
    else forever begin
      if (rem >= 2 && !de[d]) begin exp_coin[d+1] = 2; rem -= 2; end
      else if (rem >= 1 && !ne[d]) begin exp_coin[d+1] = 1; rem -= 1; end
      else begin exp_done = d + 1; exp_err = 1; exp_sf = rem; break; end
      if (rem == 0) begin exp_done = d + 2; break; end
      d += 1 + gap;
    end
  endtask

  task automatic set_flags(input int mode);
    foreach (de[i]) begin
      de[i] = (mode == 1) || (mode == 3 && $urandom_range(0, 3) == 0);
      ne[i] = (mode == 2) || (mode == 3 && $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input logic [3:0] a, input bit d, input bit n);
    b0.req_valid = v && !sel;
    b1.req_valid = v && sel;
    b0.req_amount = a;
    b1.req_amount = a;
    b0.dime_empty = d;
    b1.dime_empty = d;
    b0.nickel_empty = n;
    b1.nickel_empty = n;
  endtask

  task automatic sample(input bit sel, output logic [1:0] pulse, output logic bz, output logic dn,
                        output logic rr, output logic er, output logic [3:0] sf);
    pulse = sel ? {b1.dime, b1.nickel} : {b0.dime, b0.nickel};
    bz = sel ? b1.busy : b0.busy;
    dn = sel ? b1.done : b0.done;
    rr = sel ? b1.req_ready : b0.req_ready;
    er = sel ? b1.error : b0.error;
    sf = sel ? b1.shortfall : b0.shortfall;
  endtask

  // noisy: 0 quiet, 1 random req_valid while busy, 2 req_valid held high while busy
  task automatic run_req(input bit sel, input int amt, input int noisy);
    logic [1:0] pulse, ep;
    logic bz, dn, rr, er;
    logic [3:0] sf;
    model(amt, sel ? 0 : 2);
    @(posedge clk); #1;
    drive(sel, 1'b1, 4'(amt), de[0], ne[0]);
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(posedge clk); #1;
      drive(sel, k <= exp_done && (noisy == 2 || (noisy == 1 && $urandom_range(0, 1) == 1)),
            4'($urandom), de[k], ne[k]);
      @(negedge clk);
      sample(sel, pulse, bz, dn, rr, er, sf);
      ep = exp_coin[k] == 2 ? 2'b10 : exp_coin[k] == 1 ? 2'b01 : 2'b00;
      checks++;
      if (pulse !== ep) begin
        errors++;
        $display("FAIL pulse dut%0d amt=%0d cyc=%0d got dime,nickel=%b exp %b", sel, amt, k, pulse, ep);
      end
      checks++;
      if (dn !== (k == exp_done)) begin
        errors++;
        $display("FAIL done dut%0d amt=%0d cyc=%0d got %b exp %b", sel, amt, k, dn, k == exp_done);
      end
      checks++;
      if ({bz, rr} !== {k <= exp_done, k > exp_done}) begin
        errors++;
        $display("FAIL busy_ready dut%0d amt=%0d cyc=%0d got %b%b exp %b%b", sel, amt, k, bz, rr,
                 k <= exp_done, k > exp_done);
      end
      checks++;
      if (k >= exp_done ? ({er, sf} !== {exp_err, 4'(exp_sf)}) : ({er, sf} !== 5'b0)) begin
        errors++;
        $display("FAIL status dut%0d amt=%0d cyc=%0d got err=%b sf=%0d exp err=%b sf=%0d", sel, amt, k,
                 er, sf, k >= exp_done ? exp_err : 1'b0, k >= exp_done ? exp_sf : 0);
      end
    end
  endtask

  task automatic test_reset();
    logic [1:0] pulse;
    logic bz, dn, rr, er;
    logic [3:0] sf;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], pulse, bz, dn, rr, er, sf);
      checks++;
      if ({pulse, bz, dn, rr, er, sf} !== {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL reset dut%0d got pulse=%b busy=%b done=%b ready=%b err=%b sf=%0d exp all 0, ready=1",
                 s, pulse, bz, dn, rr, er, sf);
      end
    end
  endtask

  task automatic test_directed();
    set_flags(0); run_req(0, 3, 0);
    set_flags(1); run_req(0, 4, 0);
    set_flags(2); run_req(0, 5, 0);
    set_flags(0); run_req(0, 15, 0);
    set_flags(1); set_flags(2); run_req(0, 1, 0);
  endtask

  task automatic test_ignore_busy();
    set_flags(0);
    run_req(0, 0, 2);
    run_req(1, 0, 2);
    run_req(0, 3, 2);
  endtask

  task automatic test_back_to_back();
    set_flags(0); run_req(1, 6, 0);
    set_flags(1); run_req(1, 3, 0);
    set_flags(2); run_req(1, 7, 0);
  endtask

  task automatic test_reset_abort();
    logic [1:0] pulse;
    logic bz, dn, rr, er;
    logic [3:0] sf;
    set_flags(0);
    @(posedge clk); #1;
    drive(0, 1'b1, 4'd10, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (b0.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre busy got %b exp 1", b0.busy);
    end
    rst_n = 1'b0;
    #1;
    sample(0, pulse, bz, dn, rr, er, sf);
    checks++;
    if ({pulse, bz, dn, rr, er, sf} !== {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL abort_async got pulse=%b busy=%b done=%b ready=%b err=%b sf=%0d exp all 0, ready=1",
               pulse, bz, dn, rr, er, sf);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sample(0, pulse, bz, dn, rr, er, sf);
      checks++;
      if ({pulse, bz, dn, rr} !== 5'b00001) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d got pulse=%b busy=%b done=%b ready=%b exp 00 0 0 1", k, pulse, bz, dn, rr);
      end
    end
    run_req(0, 2, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      set_flags(3);
      run_req($urandom_range(0, 1) == 1, $urandom_range(0, 15), 1);
    end
  endtask

  initial begin
    drive(0, 1'b0, 4'd0, 1'b0, 1'b0);
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
